// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU operand select
// and load-use hazard detection.
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REGIDX = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              ID_VALID,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [XLEN-1:0]   ID_RS1_DATA,
  input  logic [XLEN-1:0]   ID_RS2_DATA,
  input  logic [XLEN-1:0]   ID_IMM,
  input  logic [REGIDX-1:0] ID_RS1,
  input  logic [REGIDX-1:0] ID_RS2,
  input  logic [REGIDX-1:0] ID_RD,
  input  logic              ID_USE_RS1,
  input  logic              ID_USE_RS2,
  input  logic [3:0]        ID_ALU_OP,
  input  logic [1:0]        ID_ALUSRC_A,
  input  logic              ID_ALUSRC_B,
  input  logic              ID_MEM_READ,
  input  logic              ID_MEM_WRITE,
  input  logic              ID_REG_WRITE,
  input  logic              MEM_REG_WRITE,
  input  logic [REGIDX-1:0] MEM_RD,
  input  logic [XLEN-1:0]   MEM_RESULT,
  input  logic              WB_REG_WRITE,
  input  logic [REGIDX-1:0] WB_RD,
  input  logic [XLEN-1:0]   WB_DATA,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [3:0]        OPERATION,
  output logic              EX_VALID,
  output logic [XLEN-1:0]   EX_PC,
  output logic [XLEN-1:0]   EX_STORE_DATA,
  output logic [REGIDX-1:0] EX_RD,
  output logic              EX_MEM_READ,
  output logic              EX_MEM_WRITE,
  output logic              EX_REG_WRITE,
  output logic              STALL
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REGIDX-1:0] rs1;
    logic [REGIDX-1:0] rs2;
    logic [REGIDX-1:0] rd;
    logic [3:0]        alu_op;
    logic [1:0]        src_a;
    logic              src_b;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } stage_t;

  stage_t            stage_d, stage_q;
  logic              stall_c;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

  // Load in EX whose rd is read by the instruction in ID.
  always_comb begin
    stall_c = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && ID_VALID &&
              ((ID_USE_RS1 && (ID_RS1 == stage_q.rd)) ||
               (ID_USE_RS2 && (ID_RS2 == stage_q.rd)));
  end

  // Next stage contents: a zeroed bubble on flush or stall, otherwise capture ID.
  always_comb begin
    stage_d = '0;
    if (!(FLUSH || stall_c)) begin
      stage_d.valid     = ID_VALID;
      stage_d.pc        = ID_PC;
      stage_d.rs1_data  = ID_RS1_DATA;
      stage_d.rs2_data  = ID_RS2_DATA;
      stage_d.imm       = ID_IMM;
      stage_d.rs1       = ID_RS1;
      stage_d.rs2       = ID_RS2;
      stage_d.rd        = ID_RD;
      stage_d.alu_op    = ID_ALU_OP;
      stage_d.src_a     = ID_ALUSRC_A;
      stage_d.src_b     = ID_ALUSRC_B;
      stage_d.mem_read  = ID_MEM_READ;
      stage_d.mem_write = ID_MEM_WRITE;
      stage_d.reg_write = ID_REG_WRITE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  // MEM beats WB; x0 is never forwarded.
  always_comb begin
    rs1_fwd = stage_q.rs1_data;
    if (MEM_REG_WRITE && (MEM_RD != '0) && (MEM_RD == stage_q.rs1))
      rs1_fwd = MEM_RESULT;
    else if (WB_REG_WRITE && (WB_RD != '0) && (WB_RD == stage_q.rs1))
      rs1_fwd = WB_DATA;

    rs2_fwd = stage_q.rs2_data;
    if (MEM_REG_WRITE && (MEM_RD != '0) && (MEM_RD == stage_q.rs2))
      rs2_fwd = MEM_RESULT;
    else if (WB_REG_WRITE && (WB_RD != '0) && (WB_RD == stage_q.rs2))
      rs2_fwd = WB_DATA;
  end

  always_comb begin
    case (stage_q.src_a)
      2'd0:    A = rs1_fwd;
      2'd1:    A = stage_q.pc;
      default: A = '0;
    endcase
    B             = stage_q.src_b ? stage_q.imm : rs2_fwd;
    OPERATION     = stage_q.valid ? stage_q.alu_op : 4'd0;
    EX_VALID      = stage_q.valid;
    EX_PC         = stage_q.pc;
    EX_STORE_DATA = rs2_fwd;
    EX_RD         = stage_q.rd;
    EX_MEM_READ   = stage_q.mem_read  && stage_q.valid;
    EX_MEM_WRITE  = stage_q.mem_write && stage_q.valid;
    EX_REG_WRITE  = stage_q.reg_write && stage_q.valid;
    STALL         = stall_c;
  end

endmodule
